// File: rtl/finger_play_match_ctrl.sv
// Rock/scissors/paper match controller for NUM_PLAYERS players.
// It latches one-hot gestures inside a timed window, judges each round and keeps saturating scores.
module finger_play_match_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 4,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                           Sys_Clk,
  input  logic                           Sys_Rst,
  input  logic                           BTN_Ready,
  input  logic                           BTN_Go,
  input  logic [3*NUM_PLAYERS-1:0]       BTN_Player,
  output logic [2:0]                     State,
  output logic [3*NUM_PLAYERS-1:0]       Choice,
  output logic [NUM_PLAYERS-1:0]         Round_Winner,
  output logic                           Round_Done,
  output logic [SCORE_W*NUM_PLAYERS-1:0] Score,
  output logic [NUM_PLAYERS-1:0]         Match_Winner,
  output logic                           Match_Done,
  output logic                           Timeout_Flag
);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    CHOOSE = 3'd2,
    JUDGE  = 3'd3,
    SHOW   = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t                         state, state_nxt;
  logic                           ready_prev, go_prev;
  logic [3*NUM_PLAYERS-1:0]       player_prev;
  logic                           ready_rise, go_rise;
  logic [3*NUM_PLAYERS-1:0]       player_rise;
  logic [TIMER_W-1:0]             timer, timer_nxt;
  logic [3*NUM_PLAYERS-1:0]       choice_nxt, choice_latched;
  logic [NUM_PLAYERS-1:0]         round_winner_nxt, match_winner_nxt;
  logic [NUM_PLAYERS-1:0]         judge_winner, judge_match;
  logic [SCORE_W*NUM_PLAYERS-1:0] score_nxt, score_judged;
  logic                           round_done_nxt, match_done_nxt, timeout_flag_nxt;
  logic                           all_chosen, any_unchosen;
  logic [2:0]                     lvl, gest_seen, win_gest, n_valid;
  logic [SCORE_W-1:0]             s;

  assign ready_rise  = BTN_Ready & ~ready_prev;
  assign go_rise     = BTN_Go & ~go_prev;
  assign player_rise = BTN_Player & ~player_prev;
  assign State       = state;

  // Gesture latching for the choice window and the round verdict from the registered choices.
  always_comb begin
    all_chosen     = 1'b1;
    any_unchosen   = 1'b0;
    choice_latched = Choice;
    gest_seen      = '0;
    n_valid        = '0;
    lvl            = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      lvl = BTN_Player[3*p +: 3];
      if (Choice[3*p +: 3] == 3'b000) begin
        all_chosen = 1'b0;
        if ((|player_rise[3*p +: 3]) && (lvl == 3'b001 || lvl == 3'b010 || lvl == 3'b100))
          choice_latched[3*p +: 3] = lvl;
      end else begin
        n_valid   = n_valid + 3'd1;
        gest_seen = gest_seen | Choice[3*p +: 3];
      end
      if (choice_latched[3*p +: 3] == 3'b000) any_unchosen = 1'b1;
    end

    // Exactly two distinct gestures: rock beats scissors, scissors beats paper, paper beats rock.
    case (gest_seen)
      3'b011:  win_gest = 3'b001;
      3'b110:  win_gest = 3'b010;
      3'b101:  win_gest = 3'b100;
      default: win_gest = 3'b000;
    endcase

    judge_winner = '0;
    judge_match  = '0;
    score_judged = Score;
    s            = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (n_valid == 3'd1) judge_winner[p] = |Choice[3*p +: 3];
      else judge_winner[p] = (win_gest != 3'b000) && (Choice[3*p +: 3] == win_gest);
      s = Score[SCORE_W*p +: SCORE_W];
      if (judge_winner[p] && (s < WIN_VAL)) s = s + SCORE_W'(1);
      score_judged[SCORE_W*p +: SCORE_W] = s;
      judge_match[p] = (s == WIN_VAL);
    end
  end

  always_comb begin
    state_nxt        = state;
    choice_nxt       = Choice;
    round_winner_nxt = Round_Winner;
    score_nxt        = Score;
    match_winner_nxt = Match_Winner;
    timeout_flag_nxt = Timeout_Flag;
    timer_nxt        = timer;
    round_done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        score_nxt        = '0;
        choice_nxt       = '0;
        round_winner_nxt = '0;
        match_winner_nxt = '0;
        timeout_flag_nxt = 1'b0;
        if (ready_rise) state_nxt = READY;
      end
      READY, SHOW: begin
        if (ready_rise) begin
          state_nxt  = READY;
          score_nxt  = '0;
          choice_nxt = '0;
        end else if (go_rise) begin
          state_nxt        = CHOOSE;
          choice_nxt       = '0;
          timer_nxt        = '0;
          timeout_flag_nxt = 1'b0;
        end
      end
      CHOOSE: begin
        if (ready_rise) begin
          state_nxt  = READY;
          score_nxt  = '0;
          choice_nxt = '0;
        end else begin
          choice_nxt = choice_latched;
          timer_nxt  = timer + TIMER_W'(1);
          // A completed set of choices wins over an expiring window, so no timeout is flagged.
          if (all_chosen) begin
            state_nxt = JUDGE;
          end else if (timer == TIMER_LAST) begin
            state_nxt        = JUDGE;
            timeout_flag_nxt = any_unchosen;
          end
        end
      end
      JUDGE: begin
        round_winner_nxt = judge_winner;
        score_nxt        = score_judged;
        round_done_nxt   = 1'b1;
        if (|judge_match) begin
          state_nxt        = OVER;
          match_winner_nxt = judge_match;
        end else begin
          state_nxt = SHOW;
        end
      end
      OVER: begin
        if (ready_rise) begin
          state_nxt        = READY;
          score_nxt        = '0;
          match_winner_nxt = '0;
          round_winner_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    match_done_nxt = (state_nxt == OVER);
  end

  // Edge history resets to ones so that buttons held through reset do not register as presses.
  always_ff @(posedge Sys_Clk) begin
    if (Sys_Rst) begin
      state        <= IDLE;
      Choice       <= '0;
      Round_Winner <= '0;
      Round_Done   <= 1'b0;
      Score        <= '0;
      Match_Winner <= '0;
      Match_Done   <= 1'b0;
      Timeout_Flag <= 1'b0;
      timer        <= '0;
      ready_prev   <= 1'b1;
      go_prev      <= 1'b1;
      player_prev  <= '1;
    end else begin
      state        <= state_nxt;
      Choice       <= choice_nxt;
      Round_Winner <= round_winner_nxt;
      Round_Done   <= round_done_nxt;
      Score        <= score_nxt;
      Match_Winner <= match_winner_nxt;
      Match_Done   <= match_done_nxt;
      Timeout_Flag <= timeout_flag_nxt;
      timer        <= timer_nxt;
      ready_prev   <= BTN_Ready;
      go_prev      <= BTN_Go;
      player_prev  <= BTN_Player;
    end
  end
endmodule

// File: tb/tb_finger_play_match_ctrl.sv
// Bench for finger_play_match_ctrl (3 players, first to 2, 20-cycle window).
// It uses a directed vector table, hand-written corner sequences and random play against a gesture-level model.
module tb_finger_play_match_ctrl;
  localparam int NP = 3;
  localparam int WS = 2;
  localparam int SW = 4;
  localparam int TO = 20;

  localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_CHOOSE = 3'd2;
  localparam logic [2:0] S_JUDGE = 3'd3, S_SHOW = 3'd4, S_OVER = 3'd5;
  localparam logic [8:0]  Z9  = 9'h000;
  localparam logic [2:0]  Z3  = 3'b000;
  localparam logic [11:0] Z12 = 12'h000;
  localparam logic [8:0] C1 = 9'b100_010_001;
  localparam logic [8:0] C2 = 9'b010_001_001;
  localparam logic [8:0] C3 = 9'b010_001_010;
  localparam logic [8:0] C4 = 9'b000_001_100;
  localparam logic [8:0] C5 = 9'b001_100_100;

  logic Sys_Clk = 1'b0;
  logic Sys_Rst, BTN_Ready, BTN_Go;
  logic [3*NP-1:0] BTN_Player;
  logic [2:0] State;
  logic [3*NP-1:0] Choice;
  logic [NP-1:0] Round_Winner, Match_Winner;
  logic Round_Done, Match_Done, Timeout_Flag;
  logic [SW*NP-1:0] Score;

  finger_play_match_ctrl #(.NUM_PLAYERS(NP), .WIN_SCORE(WS), .SCORE_W(SW), .TIMEOUT_CYC(TO)) dut (
    .Sys_Clk(Sys_Clk), .Sys_Rst(Sys_Rst), .BTN_Ready(BTN_Ready), .BTN_Go(BTN_Go),
    .BTN_Player(BTN_Player), .State(State), .Choice(Choice), .Round_Winner(Round_Winner),
    .Round_Done(Round_Done), .Score(Score), .Match_Winner(Match_Winner),
    .Match_Done(Match_Done), .Timeout_Flag(Timeout_Flag)
  );

  always #5 Sys_Clk = ~Sys_Clk;

  typedef struct packed {
    logic [2:0] st; logic [3*NP-1:0] ch; logic [NP-1:0] rw; logic rd;
    logic [SW*NP-1:0] sc; logic [NP-1:0] mw; logic md; logic tf;
  } out_t;

  typedef struct packed {
    logic rst; logic rdy; logic go; logic [3*NP-1:0] pl; out_t exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[32];

  // Reference model state: gestures are 0 none, 1 rock, 2 scissors, 3 paper.
  int m_state, m_timer;
  int m_gest[NP];
  int m_score[NP];
  bit m_rw[NP];
  bit m_mw[NP];
  bit m_rd, m_tf, m_prev_rdy, m_prev_go;
  logic [3*NP-1:0] m_prev_pl;

  function automatic out_t mk_out(logic [2:0] st, logic [3*NP-1:0] ch, logic [NP-1:0] rw, logic rd,
                                  logic [SW*NP-1:0] sc, logic [NP-1:0] mw, logic md, logic tf);
    out_t o;
    o.st = st; o.ch = ch; o.rw = rw; o.rd = rd; o.sc = sc; o.mw = mw; o.md = md; o.tf = tf;
    return o;
  endfunction

  function automatic vec_t mkv(logic rst, logic rdy, logic go, logic [3*NP-1:0] pl, out_t e);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.go = go; v.pl = pl; v.exp = e;
    return v;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = {State, Choice, Round_Winner, Round_Done, Score, Match_Winner, Match_Done, Timeout_Flag};
    return o;
  endfunction

  function automatic int gesture_of(logic [2:0] lvl);
    case (lvl)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit beats(int a, int b);
    return (a == 1 && b == 2) || (a == 2 && b == 3) || (a == 3 && b == 1);
  endfunction

  function automatic out_t model_out();
    out_t o;
    o = '0;
    o.st = 3'(m_state);
    for (int p = 0; p < NP; p++) begin
      o.ch[3*p +: 3] = (m_gest[p] == 0) ? 3'b000 : 3'(1 << (m_gest[p] - 1));
      o.rw[p] = m_rw[p];
      o.mw[p] = m_mw[p];
      o.sc[SW*p +: SW] = SW'(m_score[p]);
    end
    o.rd = m_rd;
    o.md = (m_state == 5);
    o.tf = m_tf;
    return o;
  endfunction

  task automatic model_step(input logic rst, input logic rdy, input logic go, input logic [3*NP-1:0] pl);
    bit rdy_rise, go_rise, all_in, at_last, any_over;
    bit seen[4];
    int nvalid, ndist, win_g;
    if (rst) begin
      m_state = 0; m_timer = 0; m_rd = 0; m_tf = 0;
      for (int p = 0; p < NP; p++) begin
        m_gest[p] = 0; m_score[p] = 0; m_rw[p] = 0; m_mw[p] = 0;
      end
      m_prev_rdy = 1; m_prev_go = 1; m_prev_pl = '1;
      return;
    end
    rdy_rise = rdy && !m_prev_rdy;
    go_rise  = go && !m_prev_go;
    m_rd = 0;
    case (m_state)
      0: begin
        m_tf = 0;
        for (int p = 0; p < NP; p++) begin
          m_gest[p] = 0; m_score[p] = 0; m_rw[p] = 0; m_mw[p] = 0;
        end
        if (rdy_rise) m_state = 1;
      end
      1, 4: begin
        if (rdy_rise) begin
          m_state = 1;
          for (int p = 0; p < NP; p++) begin m_gest[p] = 0; m_score[p] = 0; end
        end else if (go_rise) begin
          m_state = 2; m_timer = 0; m_tf = 0;
          for (int p = 0; p < NP; p++) m_gest[p] = 0;
        end
      end
      2: begin
        if (rdy_rise) begin
          m_state = 1;
          for (int p = 0; p < NP; p++) begin m_gest[p] = 0; m_score[p] = 0; end
        end else begin
          all_in = 1;
          for (int p = 0; p < NP; p++) if (m_gest[p] == 0) all_in = 0;
          at_last = (m_timer == TO - 1);
          for (int p = 0; p < NP; p++)
            if (m_gest[p] == 0 && ((pl[3*p +: 3] & ~m_prev_pl[3*p +: 3]) != 3'b000))
              m_gest[p] = gesture_of(pl[3*p +: 3]);
          m_timer++;
          if (all_in) m_state = 3;
          else if (at_last) begin
            m_state = 3;
            m_tf = 0;
            for (int p = 0; p < NP; p++) if (m_gest[p] == 0) m_tf = 1;
          end
        end
      end
      3: begin
        nvalid = 0; ndist = 0; win_g = 0; any_over = 0;
        seen = '{default: 0};
        for (int p = 0; p < NP; p++) if (m_gest[p] != 0) begin nvalid++; seen[m_gest[p]] = 1; end
        for (int g = 1; g <= 3; g++) if (seen[g]) ndist++;
        if (ndist == 2)
          for (int a = 1; a <= 3; a++)
            for (int b = 1; b <= 3; b++)
              if (seen[a] && seen[b] && beats(a, b)) win_g = a;
        for (int p = 0; p < NP; p++) begin
          m_rw[p] = (nvalid == 1) ? (m_gest[p] != 0) : (win_g != 0 && m_gest[p] == win_g);
          if (m_rw[p] && m_score[p] < WS) m_score[p]++;
          m_mw[p] = (m_score[p] == WS);
          if (m_mw[p]) any_over = 1;
        end
        m_state = any_over ? 5 : 4;
        m_rd = 1;
      end
      5: begin
        if (rdy_rise) begin
          m_state = 1;
          for (int p = 0; p < NP; p++) begin m_score[p] = 0; m_mw[p] = 0; m_rw[p] = 0; end
        end
      end
      default: m_state = 0;
    endcase
    m_prev_rdy = rdy; m_prev_go = go; m_prev_pl = pl;
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic go, input logic [3*NP-1:0] pl);
    Sys_Rst = rst; BTN_Ready = rdy; BTN_Go = go; BTN_Player = pl;
    @(posedge Sys_Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input out_t exp);
    out_t act;
    act = dut_out();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: got st=%0d ch=%b rw=%b rd=%b sc=%h mw=%b md=%b tf=%b, expected st=%0d ch=%b rw=%b rd=%b sc=%h mw=%b md=%b tf=%b",
               name, idx, act.st, act.ch, act.rw, act.rd, act.sc, act.mw, act.md, act.tf,
               exp.st, exp.ch, exp.rw, exp.rd, exp.sc, exp.mw, exp.md, exp.tf);
    end
  endtask

  initial begin
    logic [3*NP-1:0] pl;
    logic rst, rdy, go;
    out_t zero_out;
    zero_out = mk_out(S_IDLE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0);

    tbl[0]  = mkv(1'b0, 1'b0, 1'b0, Z9, zero_out);
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, Z9, mk_out(S_READY,  Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[2]  = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_READY,  Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[3]  = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_CHOOSE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[4]  = mkv(1'b0, 1'b0, 1'b0, C1, mk_out(S_CHOOSE, C1, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, C1, mk_out(S_JUDGE,  C1, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, C1, mk_out(S_SHOW,   C1, Z3, 1'b1, Z12, Z3, 1'b0, 1'b0));
    tbl[7]  = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_SHOW,   C1, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[8]  = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_CHOOSE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, C2, mk_out(S_CHOOSE, C2, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, C2, mk_out(S_JUDGE,  C2, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, C2, mk_out(S_SHOW,   C2, 3'b011, 1'b1, 12'h011, Z3, 1'b0, 1'b0));
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_SHOW,   C2, 3'b011, 1'b0, 12'h011, Z3, 1'b0, 1'b0));
    tbl[13] = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_CHOOSE, Z9, 3'b011, 1'b0, 12'h011, Z3, 1'b0, 1'b0));
    tbl[14] = mkv(1'b0, 1'b0, 1'b0, C3, mk_out(S_CHOOSE, C3, 3'b011, 1'b0, 12'h011, Z3, 1'b0, 1'b0));
    tbl[15] = mkv(1'b0, 1'b0, 1'b0, C3, mk_out(S_JUDGE,  C3, 3'b011, 1'b0, 12'h011, Z3, 1'b0, 1'b0));
    tbl[16] = mkv(1'b0, 1'b0, 1'b0, C3, mk_out(S_OVER,   C3, 3'b010, 1'b1, 12'h021, 3'b010, 1'b1, 1'b0));
    tbl[17] = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_OVER,   C3, 3'b010, 1'b0, 12'h021, 3'b010, 1'b1, 1'b0));
    tbl[18] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_OVER,   C3, 3'b010, 1'b0, 12'h021, 3'b010, 1'b1, 1'b0));
    tbl[19] = mkv(1'b0, 1'b1, 1'b0, Z9, mk_out(S_READY,  C3, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[20] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_READY,  C3, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[21] = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_CHOOSE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[22] = mkv(1'b0, 1'b0, 1'b0, C4, mk_out(S_CHOOSE, C4, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[23] = mkv(1'b0, 1'b1, 1'b0, C4, mk_out(S_READY,  Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[24] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_READY,  Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[25] = mkv(1'b0, 1'b0, 1'b1, Z9, mk_out(S_CHOOSE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[26] = mkv(1'b0, 1'b0, 1'b0, C5, mk_out(S_CHOOSE, C5, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[27] = mkv(1'b0, 1'b0, 1'b0, C5, mk_out(S_JUDGE,  C5, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[28] = mkv(1'b0, 1'b0, 1'b0, C5, mk_out(S_SHOW,   C5, 3'b011, 1'b1, 12'h011, Z3, 1'b0, 1'b0));
    tbl[29] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_SHOW,   C5, 3'b011, 1'b0, 12'h011, Z3, 1'b0, 1'b0));
    tbl[30] = mkv(1'b0, 1'b1, 1'b1, Z9, mk_out(S_READY,  Z9, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b0));
    tbl[31] = mkv(1'b0, 1'b0, 1'b0, Z9, mk_out(S_READY,  Z9, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b0));

    applyStimulus(1'b1, 1'b0, 1'b0, Z9);
    applyStimulus(1'b1, 1'b0, 1'b0, Z9);
    checkOutput("reset", 0, zero_out);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].rdy, tbl[i].go, tbl[i].pl);
      checkOutput("table", i, tbl[i].exp);
    end

    // Timeout: P0 scissors, P1 holds an illegal two-bit level, P2 never presses.
    applyStimulus(1'b0, 1'b0, 1'b1, Z9);
    checkOutput("to_choose", 0, mk_out(S_CHOOSE, Z9, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 9'b000_011_010);
    checkOutput("multibit_ignored", 0, mk_out(S_CHOOSE, 9'h002, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b0));
    for (int k = 2; k <= 19; k++) applyStimulus(1'b0, 1'b0, 1'b0, 9'b000_011_010);
    checkOutput("window_open", 19, mk_out(S_CHOOSE, 9'h002, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 9'b000_011_010);
    checkOutput("timeout_judge", 20, mk_out(S_JUDGE, 9'h002, 3'b011, 1'b0, Z12, Z3, 1'b0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, Z9);
    checkOutput("timeout_winner", 21, mk_out(S_SHOW, 9'h002, 3'b001, 1'b1, 12'h001, Z3, 1'b0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b1, Z9);
    checkOutput("go_clears_timeout", 0, mk_out(S_CHOOSE, Z9, 3'b001, 1'b0, 12'h001, Z3, 1'b0, 1'b0));

    // Reset mid-window with P0 holding rock throughout.
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    checkOutput("latch_rock", 0, mk_out(S_CHOOSE, 9'h001, 3'b001, 1'b0, 12'h001, Z3, 1'b0, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h001);
    checkOutput("mid_reset", 0, zero_out);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    checkOutput("post_reset_idle", 0, zero_out);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h001);
    checkOutput("ready_after_reset", 0, mk_out(S_READY, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    checkOutput("held_rock_ignored", 0, mk_out(S_CHOOSE, Z9, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, Z9);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h001);
    checkOutput("repress_latch", 0, mk_out(S_CHOOSE, 9'h001, Z3, 1'b0, Z12, Z3, 1'b0, 1'b0));

    // Random play against the reference model, starting from a fresh reset.
    for (int c = 0; c < 3000; c++) begin
      rst = (c < 2) || ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 24) == 0);
      go  = ($urandom_range(0, 2) == 0);
      pl  = BTN_Player;
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          0:       pl[3*p +: 3] = 3'b000;
          1:       pl[3*p +: 3] = 3'b001 << $urandom_range(0, 2);
          2:       pl[3*p +: 3] = BTN_Player[3*p +: 3];
          default: pl[3*p +: 3] = 3'($urandom_range(0, 7));
        endcase
      end
      model_step(rst, rdy, go, pl);
      applyStimulus(rst, rdy, go, pl);
      checkOutput("random", c, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
